// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial add/subtract sequencer.
package serial_add_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Counter must be able to hold 0..WIDTH.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle between a command source and the serial adder.
interface serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/halfadder.sv
// Single-bit half adder cell.
module halfadder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract: one full-adder slice (two half adders) walks the
// operands LSB-first, one bit per clock, behind valid/ready handshakes.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    serial_add_ctrl_if.slave bus
);
    import serial_add_pkg::*;

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;

    logic s1, c1, bit_s, c2;

    halfadder ha1 (
        .a (a_q[0]),
        .b (b_q[0]),
        .s (s1),
        .c (c1)
    );

    halfadder ha2 (
        .a (s1),
        .b (carry_q),
        .s (bit_s),
        .c (c2)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    // Subtract as a + ~b + 1: the +1 enters as the initial carry.
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                carry_d          = c1 | c2;
                sum_d            = sum_q >> 1;
                sum_d[WIDTH-1]   = bit_s;
                a_d              = a_q >> 1;
                b_d              = b_q >> 1;
                cnt_d            = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.sum       = sum_q;
    assign bus.cout      = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench: WIDTH=8 and WIDTH=1 instances against an arithmetic model.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 transaction; expected result from plain modular arithmetic.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input int hold, input bit junk, input string tag);
        logic [8:0] full;
        logic [7:0] es;
        logic       ec;
        int         n;
        if (s) begin
            es = 8'(a - b);
            ec = (a >= b);
        end else begin
            full = {1'b0, a} + {1'b0, b};
            es   = full[7:0];
            ec   = full[8];
        end
        n = 0;
        while (!bus8.in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_rdy"}, 32'(bus8.in_ready), 32'd1);
        bus8.a = a; bus8.b = b; bus8.sub = s; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        n = 0;
        while (!bus8.out_valid && n < 50) begin
            bus8.in_valid = junk && (n == 3);
            bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.sub = 1'($urandom);
            @(posedge clk); #1; n++;
        end
        bus8.in_valid = 1'b0;
        chk({tag, "_lat"}, 32'(n), 32'd8);
        chk({tag, "_sum"}, 32'(bus8.sum), 32'(es));
        chk({tag, "_cout"}, 32'(bus8.cout), 32'(ec));
        chk({tag, "_busy"}, 32'(bus8.busy), 32'd1);
        for (int i = 0; i < hold; i++) begin
            bus8.in_valid = junk;
            bus8.a = 8'($urandom); bus8.b = 8'($urandom);
            @(posedge clk); #1;
            chk({tag, "_hold_v"}, 32'(bus8.out_valid), 32'd1);
            chk({tag, "_hold_sum"}, 32'(bus8.sum), 32'(es));
            chk({tag, "_hold_cout"}, 32'(bus8.cout), 32'(ec));
            chk({tag, "_hold_rdy"}, 32'(bus8.in_ready), 32'd0);
        end
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
        chk({tag, "_ret_v"}, 32'(bus8.out_valid), 32'd0);
        chk({tag, "_ret_rdy"}, 32'(bus8.in_ready), 32'd1);
        chk({tag, "_ret_busy"}, 32'(bus8.busy), 32'd0);
    endtask

    initial begin
        logic [2:0] v;
        int         n;
        int         e;
        rst_n = 1'b0;
        bus8.in_valid = 1'b0; bus8.out_ready = 1'b0; bus8.a = '0; bus8.b = '0; bus8.sub = 1'b0;
        bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.a = '0; bus1.b = '0; bus1.sub = 1'b0;
        #1;
        chk("rst_rdy", 32'(bus8.in_ready), 32'd1);
        chk("rst_ov", 32'(bus8.out_valid), 32'd0);
        chk("rst_busy", 32'(bus8.busy), 32'd0);
        chk("rst_sum", 32'(bus8.sum), 32'd0);
        chk("rst_cout", 32'(bus8.cout), 32'd0);
        #12 rst_n = 1'b1;
        @(posedge clk); #1;

        op8(8'h0F, 8'h01, 1'b0, 0, 1'b0, "add0f01");
        op8(8'hFF, 8'h01, 1'b0, 0, 1'b0, "addff01");
        op8(8'h05, 8'h07, 1'b1, 0, 1'b0, "sub0507");
        op8(8'h07, 8'h05, 1'b1, 5, 1'b1, "sub0705_bp");
        for (int k = 0; k < 20; k++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                1'($urandom), "rand");
        end
        op8(8'h00, 8'h00, 1'b1, 0, 1'b0, "sub0000");

        // WIDTH=1 exhaustive sweep
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            bus1.a = v[0]; bus1.b = v[1]; bus1.sub = v[2]; bus1.in_valid = 1'b1;
            @(posedge clk); #1;
            bus1.in_valid = 1'b0;
            n = 0;
            while (!bus1.out_valid && n < 20) begin
                @(posedge clk); #1; n++;
            end
            e = v[2] ? (int'(v[0]) - int'(v[1])) : (int'(v[0]) + int'(v[1]));
            chk("w1_lat", 32'(n), 32'd1);
            chk("w1_sum", 32'(bus1.sum), 32'(e & 1));
            chk("w1_cout", 32'(bus1.cout),
                v[2] ? 32'(v[0] >= v[1]) : 32'((e >> 1) & 1));
            bus1.out_ready = 1'b1;
            @(posedge clk); #1;
            bus1.out_ready = 1'b0;
            chk("w1_ret_rdy", 32'(bus1.in_ready), 32'd1);
        end

        // Reset in the middle of RUN
        bus8.a = 8'hAA; bus8.b = 8'h55; bus8.sub = 1'b0; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("mid_busy_pre", 32'(bus8.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rdy", 32'(bus8.in_ready), 32'd1);
        chk("mid_rst_ov", 32'(bus8.out_valid), 32'd0);
        chk("mid_rst_busy", 32'(bus8.busy), 32'd0);
        chk("mid_rst_sum", 32'(bus8.sum), 32'd0);
        chk("mid_rst_cout", 32'(bus8.cout), 32'd0);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("mid_no_ov", 32'(bus8.out_valid), 32'd0);
        end
        op8(8'h3C, 8'hC3, 1'b0, 2, 1'b0, "add3cc3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial add/subtract sequencer built around the existing `halfadder` cell. It accepts one pair of WIDTH-bit operands per transaction over a valid/ready handshake and steps the operands LSB-first through a single full-adder slice, one bit per clock. The slice is two `halfadder` instances plus an OR. The block trades latency for area and sits between a command source and a result consumer wherever a full-width adder is too costly.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range ≥ 1.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair and `sub` are valid.
- `in_ready`  out  1  block can accept an operation.
- `a`  in  WIDTH  first operand, unsigned.
- `b`  in  WIDTH  second operand, unsigned.
- `sub`  in  1  0 = a+b, 1 = a−b (two's complement).
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `sum`  out  WIDTH  result bits.
- `cout`  out  1  final carry; for subtract, 1 = no borrow (a ≥ b).
- `busy`  out  1  high in RUN or DONE.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - RUN: bit processing.
  - DONE: `out_valid`=1.
- IDLE → RUN on an edge with `in_valid && in_ready`. Capture:
  - a_sh ← a.
  - b_sh ← sub ? ~b : b.
  - carry ← sub.
  - cnt ← 0.
  - sum_sh ← 0.
- Each RUN edge performs one bit step:
  - HA1 takes (a_sh[0], b_sh[0]) and produces (s1, c1).
  - HA2 takes (s1, carry) and produces (bit, c2).
  - carry ← c1 | c2.
  - sum_sh ← {bit, sum_sh[WIDTH-1:1]}.
  - a_sh, b_sh shift right by 1.
  - cnt ← cnt+1.
- RUN → DONE on the edge where cnt == WIDTH−1; that edge performs the final bit step.
- DONE → IDLE on an edge with `out_ready`=1.
- `sum` = sum_sh and `cout` = carry. Both are stable and unchanged throughout DONE.
- `in_valid` outside IDLE is ignored. The source must hold `a`, `b`, `sub` only until accepted.
- cnt width is $clog2(WIDTH+1). For WIDTH=1, RUN lasts exactly one edge.
- Arithmetic is modulo 2^WIDTH. No overflow flag.

## Timing
- Reset (async assert, sync-to-clk deassert is handled upstream) forces:
  - state=IDLE.
  - `in_ready`=1.
  - `out_valid`=0.
  - `busy`=0.
  - `sum`=0.
  - `cout`=0.
  - All shift registers and cnt cleared.
- Accept edge = edge 0. `out_valid` rises after edge WIDTH. Latency = WIDTH cycles.
- Result held indefinitely under backpressure (`out_ready`=0).
- On the edge where `out_ready`=1 in DONE: `out_valid` falls and `in_ready` rises.
- No accept in the same cycle as result retire, since `in_ready`=0 in DONE. Next accept is possible one cycle later.
- Peak throughput: one operation per WIDTH+2 cycles.
- Reset mid-RUN or mid-DONE: immediate return to IDLE with reset values. The in-flight result is discarded and `out_valid` is never asserted for it.
- `in_ready`, `out_valid`, `busy` are decoded from registered state only, with no combinational path from inputs.

## Structure
- Package `serial_add_pkg`:
  - state enum {IDLE, RUN, DONE}, 2-bit encoding.
  - localparam helper for the counter width.
- Sub-module: reuse the existing `halfadder` module, two instances forming the bit-slice. No new sub-module.
- Target size: ~150 lines RTL.

## Test plan
All cases use WIDTH=8 unless noted.
- Add 8'h0F + 8'h01, sub=0 → `sum`=8'h10, `cout`=0; `out_valid` high exactly 8 cycles after the accept edge.
- Add 8'hFF + 8'h01 → `sum`=8'h00, `cout`=1.
- Subtract, sub=1:
  - 8'h05 − 8'h07 → `sum`=8'hFE, `cout`=0.
  - 8'h07 − 8'h05 → `sum`=8'h02, `cout`=1.
- Backpressure:
  - Hold `out_ready`=0 for 5 cycles after `out_valid`: `sum`/`cout` stable and `in_ready`=0 throughout.
  - Pulse `in_valid` with new operands during RUN/DONE: ignored, result unchanged.
- Reset mid-operation: assert `rst_n`=0 at cycle 4 of RUN → all outputs at reset values in the same cycle, no `out_valid`. The next op, 8'h3C + 8'hC3, gives `sum`=8'hFF, `cout`=0.
- WIDTH=1 sweep of all 8 (a, b, sub) combinations → correct `sum`/`cout`, 1-cycle latency.
